// File: rtl/sha256_msg_feeder.sv
// SHA-256 message front end: pads a byte-serial message and appends its bit length.
// Issues 512-bit blocks with the chaining value to the round engine, then presents the final digest.
module sha256_msg_feeder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din_v,
    input  logic [7:0]   din_byte,
    input  logic         din_keep,
    input  logic         din_last,
    output logic         din_rdy,
    output logic [511:0] M_out,
    output logic [255:0] H_out,
    output logic         blk_v,
    input  logic [255:0] res,
    input  logic         res_v,
    output logic [255:0] digest,
    output logic         digest_v
);

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_PAD   = 3'd1,
        S_ZERO  = 3'd2,
        S_LEN   = 3'd3,
        S_ISSUE = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t         state_q, state_d;
    state_t         resume_q, resume_d;
    logic [5:0]     idx_q, idx_d;
    logic [60:0]    cnt_q, cnt_d;
    logic [511:0]   blk_q, blk_d;
    logic [255:0]   h_q, h_d;
    logic           final_q, final_d;
    logic [511:0]   m_out_q, m_out_d;
    logic [255:0]   h_out_q, h_out_d;
    logic           blk_v_q, blk_v_d;
    logic           din_rdy_q, din_rdy_d;
    logic [255:0]   digest_q, digest_d;
    logic           digest_v_q, digest_v_d;

    // Byte 0 occupies the top of the block, so byte k starts at bit 511-8k.
    function automatic logic [511:0] put_byte(input logic [511:0] blk, input logic [5:0] pos,
                                              input logic [7:0] val);
        logic [511:0] r;
        r = blk;
        r[{~pos, 3'b111} -: 8] = val;
        return r;
    endfunction

    // Next-state and datapath updates for the fill / pad / issue / wait sequence.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        blk_d    = blk_q;
        h_d      = h_q;
        final_d  = final_q;
        case (state_q)
            S_FILL: begin
                if (din_v && din_rdy_q) begin
                    if (din_keep) begin
                        blk_d = put_byte(blk_q, idx_q, din_byte);
                        idx_d = idx_q + 6'd1;
                        cnt_d = cnt_q + 61'd1;
                        if (idx_q == 6'd63) begin
                            state_d  = S_ISSUE;
                            resume_d = din_last ? S_PAD : S_FILL;
                        end else if (din_last) begin
                            state_d = S_PAD;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else if (din_last) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_PAD: begin
                blk_d = put_byte(blk_q, idx_q, 8'h80);
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    state_d  = S_ISSUE;
                    resume_d = S_ZERO;
                end else begin
                    state_d = S_ZERO;
                end
            end
            S_ZERO: begin
                if (idx_q == 6'd56) begin
                    state_d = S_LEN;
                end else begin
                    blk_d = put_byte(blk_q, idx_q, 8'h00);
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        state_d  = S_ISSUE;
                        resume_d = S_ZERO;
                    end else begin
                        state_d = S_ZERO;
                    end
                end
            end
            S_LEN: begin
                blk_d[63:0] = {cnt_q, 3'b000};
                final_d     = 1'b1;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (res_v) begin
                    h_d     = res;
                    idx_d   = 6'd0;
                    blk_d   = 512'd0;
                    state_d = final_q ? S_DONE : resume_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                h_d     = IV;
                cnt_d   = 61'd0;
                final_d = 1'b0;
                state_d = S_FILL;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Outputs are computed from the next state so each registered strobe lines up with its state.
    always_comb begin
        din_rdy_d  = (state_d == S_FILL);
        blk_v_d    = (state_d == S_ISSUE);
        digest_v_d = (state_d == S_DONE);
        m_out_d    = (state_d == S_ISSUE) ? blk_d : m_out_q;
        h_out_d    = (state_d == S_ISSUE) ? h_d : h_out_q;
        digest_d   = (state_d == S_DONE) ? h_d : digest_q;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            resume_q   <= S_FILL;
            idx_q      <= 6'd0;
            cnt_q      <= 61'd0;
            blk_q      <= 512'd0;
            h_q        <= IV;
            final_q    <= 1'b0;
            m_out_q    <= 512'd0;
            h_out_q    <= IV;
            blk_v_q    <= 1'b0;
            din_rdy_q  <= 1'b0;
            digest_q   <= 256'd0;
            digest_v_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            blk_q      <= blk_d;
            h_q        <= h_d;
            final_q    <= final_d;
            m_out_q    <= m_out_d;
            h_out_q    <= h_out_d;
            blk_v_q    <= blk_v_d;
            din_rdy_q  <= din_rdy_d;
            digest_q   <= digest_d;
            digest_v_q <= digest_v_d;
        end
    end

    assign din_rdy  = din_rdy_q;
    assign M_out    = m_out_q;
    assign H_out    = h_out_q;
    assign blk_v    = blk_v_q;
    assign digest   = digest_q;
    assign digest_v = digest_v_q;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: behavioural SHA-256 engine plus a padding/hash reference model,
// known-answer table, randomized messages and a reset-during-WAIT sequence.
module tb_sha256_msg_feeder;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] DIG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_56 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk;
    logic         rst_n;
    logic         din_v;
    logic [7:0]   din_byte;
    logic         din_keep;
    logic         din_last;
    logic         din_rdy;
    logic [511:0] M_out;
    logic [255:0] H_out;
    logic         blk_v;
    logic [255:0] res;
    logic         res_v;
    logic [255:0] digest;
    logic         digest_v;

    sha256_msg_feeder dut (
        .clk(clk), .rst_n(rst_n), .din_v(din_v), .din_byte(din_byte), .din_keep(din_keep),
        .din_last(din_last), .din_rdy(din_rdy), .M_out(M_out), .H_out(H_out), .blk_v(blk_v),
        .res(res), .res_v(res_v), .digest(digest), .digest_v(digest_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0]   msg_q[$];
    logic [511:0] exp_m[$];
    logic [255:0] exp_h[$];
    logic [255:0] exp_dig;
    logic [511:0] got_m[$];
    logic [255:0] got_h[$];
    logic [255:0] got_dig;
    int dig_seen = 0;
    int dig_cyc = 0;
    int res_cyc = 0;
    int rdy_viol = 0;
    bit in_wait = 1'b0;
    int eng_lat = 64;
    int pend_due[$];
    logic [255:0] pend_res[$];

    typedef struct {
        string        name;
        int           kind;
        int           len;
        bit           known;
        logic [255:0] dig;
        int           nblk;
        int           pad_blk;
        int           pad_pos;
        logic [63:0]  lenbits;
    } vec_t;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Engine model and output monitor, sampling away from the rising edge.
    initial begin
        res_v = 1'b0;
        res   = 256'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (blk_v === 1'b1) begin
                got_m.push_back(M_out);
                got_h.push_back(H_out);
                pend_due.push_back(cyc + eng_lat);
                pend_res.push_back(sha_compress(H_out, M_out));
                in_wait = 1'b1;
            end
            if (in_wait && din_rdy === 1'b1) rdy_viol++;
            if (digest_v === 1'b1) begin
                got_dig = digest;
                dig_seen++;
                dig_cyc = cyc;
            end
            res_v = 1'b0;
            for (int i = 0; i < pend_due.size(); i++) begin
                if (pend_due[i] == cyc) begin
                    res_v   = 1'b1;
                    res     = pend_res[i];
                    res_cyc = cyc;
                    in_wait = 1'b0;
                    pend_due.delete(i);
                    pend_res.delete(i);
                    break;
                end
            end
        end
    end

    task automatic build_msg(input int kind, input int len);
        string s;
        if (kind == 0) s = "abc";
        else if (kind == 2) s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        else s = "";
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back((kind == 3) ? 8'(i * 37 + 5) : 8'(s[i]));
    endtask

    // Reference: standard SHA-256 padding on a byte list, then chained compression.
    task automatic build_model();
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        logic [255:0] h;
        p = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(8'(bits >> (56 - 8*i)));
        exp_m.delete();
        exp_h.delete();
        h = IV;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            blk = 512'd0;
            for (int i = 0; i < 64; i++) blk = {blk[503:0], p[64*bi + i]};
            exp_m.push_back(blk);
            exp_h.push_back(h);
            h = sha_compress(h, blk);
        end
        exp_dig = h;
    endtask

    task automatic send_msg(input int gap_pct, input bit tail);
        int n;
        int beats;
        int wt;
        n = msg_q.size();
        beats = (n == 0 || tail) ? n + 1 : n;
        for (int i = 0; i < beats; i++) begin
            @(negedge clk);
            while ($urandom_range(99, 0) < gap_pct) begin
                din_v = 1'b0;
                @(negedge clk);
            end
            din_v = 1'b1;
            if (i < n) begin
                din_byte = msg_q[i];
                din_keep = 1'b1;
                din_last = (i == beats - 1);
            end else begin
                din_byte = 8'($urandom);
                din_keep = 1'b0;
                din_last = 1'b1;
            end
            wt = 0;
            while (din_rdy !== 1'b1 && wt < 1000) begin
                @(negedge clk);
                wt++;
            end
            if (wt >= 1000) begin
                bound_fail("din_rdy wait");
                din_v = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        din_v    = 1'b0;
        din_keep = 1'b0;
        din_last = 1'b0;
    endtask

    task automatic run_msg(input string name, input int gap_pct, input bit tail);
        int wt;
        got_m.delete();
        got_h.delete();
        dig_seen = 0;
        rdy_viol = 0;
        build_model();
        send_msg(gap_pct, tail);
        wt = 0;
        while (dig_seen == 0 && wt < 3000) begin
            @(negedge clk);
            #1;
            wt++;
        end
        if (dig_seen == 0) begin
            bound_fail({name, " digest_v"});
            return;
        end
        check({name, " block count"}, 512'(got_m.size()), 512'(exp_m.size()));
        for (int k = 0; k < exp_m.size(); k++) begin
            if (k < got_m.size()) begin
                check($sformatf("%s M_out blk%0d", name, k), got_m[k], exp_m[k]);
                check($sformatf("%s H_out blk%0d", name, k), 512'(got_h[k]), 512'(exp_h[k]));
            end
        end
        check({name, " digest"}, 512'(got_dig), 512'(exp_dig));
        check({name, " din_rdy low in ISSUE/WAIT"}, 512'(rdy_viol), 512'd0);
        check({name, " digest_v after res_v"}, 512'(dig_cyc - res_cyc), 512'd1);
        @(negedge clk);
        check({name, " din_rdy after digest_v"}, 512'(din_rdy), 512'd1);
        check({name, " digest_v one cycle"}, 512'(digest_v), 512'd0);
        check({name, " digest held"}, 512'(digest), 512'(exp_dig));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        din_v   = 1'b0;
        in_wait = 1'b0;
        @(negedge clk);
        check("reset din_rdy", 512'(din_rdy), 512'd0);
        check("reset blk_v", 512'(blk_v), 512'd0);
        check("reset digest_v", 512'(digest_v), 512'd0);
        check("reset digest", 512'(digest), 512'd0);
        check("reset M_out", M_out, 512'd0);
        check("reset H_out", 512'(H_out), 512'(IV));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("din_rdy after release", 512'(din_rdy), 512'd1);
    endtask

    initial begin
        vec_t vt[8];
        int   rlen;
        int   wt;
        logic [511:0] lastblk;
        rst_n    = 1'b0;
        din_v    = 1'b0;
        din_byte = 8'h00;
        din_keep = 1'b0;
        din_last = 1'b0;

        vt[0] = '{name:"abc",   kind:0, len:3,   known:1'b1, dig:DIG_ABC,   nblk:1, pad_blk:0, pad_pos:3,  lenbits:64'h18};
        vt[1] = '{name:"empty", kind:1, len:0,   known:1'b1, dig:DIG_EMPTY, nblk:1, pad_blk:0, pad_pos:0,  lenbits:64'h0};
        vt[2] = '{name:"56B",   kind:2, len:56,  known:1'b1, dig:DIG_56,    nblk:2, pad_blk:0, pad_pos:56, lenbits:64'h1c0};
        vt[3] = '{name:"55B",   kind:3, len:55,  known:1'b0, dig:256'd0,    nblk:1, pad_blk:0, pad_pos:55, lenbits:64'h1b8};
        vt[4] = '{name:"63B",   kind:3, len:63,  known:1'b0, dig:256'd0,    nblk:2, pad_blk:0, pad_pos:63, lenbits:64'h1f8};
        vt[5] = '{name:"64B",   kind:3, len:64,  known:1'b0, dig:256'd0,    nblk:2, pad_blk:1, pad_pos:0,  lenbits:64'h200};
        vt[6] = '{name:"100B",  kind:3, len:100, known:1'b0, dig:256'd0,    nblk:2, pad_blk:1, pad_pos:36, lenbits:64'h320};
        vt[7] = '{name:"abc2",  kind:0, len:3,   known:1'b1, dig:DIG_ABC,   nblk:1, pad_blk:0, pad_pos:3,  lenbits:64'h18};

        do_reset();

        // Known-answer and boundary table, din_v held high throughout (back-to-back messages).
        for (int i = 0; i < 8; i++) begin
            build_msg(vt[i].kind, vt[i].len);
            eng_lat = 64;
            run_msg(vt[i].name, 0, 1'b0);
            if (vt[i].known) check({vt[i].name, " known digest"}, 512'(got_dig), 512'(vt[i].dig));
            check({vt[i].name, " table block count"}, 512'(got_m.size()), 512'(vt[i].nblk));
            if (got_m.size() > vt[i].pad_blk) begin
                lastblk = got_m[vt[i].pad_blk];
                check({vt[i].name, " pad byte"}, 512'(8'(lastblk >> (504 - 8*vt[i].pad_pos))), 512'h80);
            end
            if (got_m.size() > 0) begin
                lastblk = got_m[got_m.size() - 1];
                check({vt[i].name, " length field"}, 512'(lastblk[63:0]), 512'(vt[i].lenbits));
            end
        end

        // Randomized messages, gaps, empty tails and engine latencies.
        for (int r = 0; r < 8; r++) begin
            rlen = $urandom_range(140, 0);
            msg_q.delete();
            for (int j = 0; j < rlen; j++) msg_q.push_back(8'($urandom));
            eng_lat = $urandom_range(70, 1);
            run_msg($sformatf("rnd%0d len%0d", r, rlen), $urandom_range(40, 0), 1'($urandom_range(1, 0)));
        end

        // Reset during WAIT of the second block of a 64-byte message, then "abc".
        build_msg(3, 64);
        eng_lat = 20;
        got_m.delete();
        got_h.delete();
        send_msg(0, 1'b0);
        wt = 0;
        while (got_m.size() < 2 && wt < 500) begin
            @(negedge clk);
            #1;
            wt++;
        end
        if (got_m.size() < 2) bound_fail("second block before reset");
        repeat (3) @(negedge clk);
        do_reset();
        build_msg(0, 3);
        eng_lat = 64;
        run_msg("abc after reset", 0, 1'b0);
        check("abc after reset known digest", 512'(got_dig), 512'(DIG_ABC));
        check("abc after reset blk_v count", 512'(got_m.size()), 512'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sha256_msg_feeder.md
# sha256_msg_feeder

Front end for the SHA-256 compression round engine: accepts a byte-serial message, applies SHA-256 padding and the 64-bit length field, and issues 512-bit blocks with the running chaining value to the engine. It waits for each compression result, chains it into the next block, and presents the final 256-bit digest. It is the initiator side of the engine's `M_in`/`H256_in`/`in_v` → `H256_out`/`out_v` interface.

## Interface
- No parameters. IV fixed: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din_v` in 1: input beat valid.
- `din_byte` in 8: message byte.
- `din_keep` in 1: 1 = `din_byte` is message data; 0 allowed only with `din_last`, for an empty tail.
- `din_last` in 1: final beat of the message.
- `din_rdy` out 1: beat accepted when `din_v & din_rdy`.
- `M_out` out 512: block to the engine; byte 0 is in [511:504].
- `H_out` out 256: chaining value to the engine.
- `blk_v` out 1: one-cycle block-issue strobe to the engine's `in_v`.
- `res` in 256: engine `H256_out`.
- `res_v` in 1: engine `out_v`.
- `digest` out 256: final hash.
- `digest_v` out 1: one-cycle digest-valid strobe.

## Operation
- States: FILL, PAD, ZERO, LEN, ISSUE, WAIT, DONE. Registers: 6-bit byte index `idx`, 61-bit byte count `cnt`, 512-bit block buffer, `H` (256), `final`, and `resume` (return state after WAIT).
- **FILL:** `din_rdy=1`. On each accepted beat with keep=1, write the byte at `idx`, then increment `idx` and `cnt`.
  - Byte fills position 63 and is not last → ISSUE, resume=FILL.
  - Byte fills position 63 and is last → ISSUE, resume=PAD.
  - Last beat otherwise → PAD.
  - keep=0 with last: no write → PAD.
- **PAD:** one cycle. Write 0x80 at `idx`, `idx++`.
  - Position 63 written → ISSUE, resume=ZERO.
  - Otherwise → ZERO.
- **ZERO:** write 0x00 at `idx` per cycle, `idx++`.
  - `idx`==56 on entry → LEN with no write.
  - Position 63 written → ISSUE, resume=ZERO.
- **LEN:** one cycle. Write `{cnt,3'b000}` big-endian into bytes 56..63, set `final=1` → ISSUE.
- **ISSUE:** one cycle. `blk_v=1`, `M_out`=buffer, `H_out`=`H` → WAIT.
- **WAIT:** `M_out` and `H_out` held stable. On first cycle with `res_v=1`: `H<=res`, `idx<=0`, clear the buffer.
  - `final=1` → DONE.
  - Otherwise → `resume`.
  - `res_v` outside WAIT is ignored.
- **DONE:** one cycle. `digest_v=1` with `digest=H`. Then `H<=IV`, `cnt<=0`, `final<=0` → FILL.
- `din_rdy=0` in every state except FILL. `digest` holds its value until the next DONE.
- `cnt` wraps mod 2^61. The length field is therefore mod 2^64 bits; no overflow flag.

## Timing
- Reset (async assert, sync deassert):
  - State FILL; `idx`, `cnt`, `final`, buffer cleared; `H`=IV.
  - `din_rdy=0` while `rst_n=0`, and 1 the first cycle after release.
  - `blk_v=0`, `digest_v=0`, `digest=0`, `M_out=0`, `H_out`=IV.
- Reset mid-operation: any state abandons the message immediately. A stale `res_v` after reset is ignored, since it is outside WAIT.
- Throughput: one byte per cycle in FILL.
- Pad/len cost: PAD 1 + ZERO (56−`idx`−1) + LEN 1 cycles.
- Engine latency: `res_v` arrives 64 cycles after `blk_v` for the standard engine. The feeder waits indefinitely; there is no timeout.
- `digest_v` fires the cycle after the final block's `res_v`.
- The next message's first beat is accepted the cycle after `digest_v`.
- Beats presented while `din_rdy=0` are not consumed; the source holds them.

## Test plan
- "abc" (3 beats, last on 'c') → 1 `blk_v`. Block = 61626380 00…00 00000018. `digest`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (single beat keep=0, last=1) → 1 block, 0x80 at byte 0, length 0. `digest`=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → 2 `blk_v`; second block all-zero except length 0x1C0. `digest`=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Boundary lengths:
  - 55 bytes → exactly 1 block, 0x80 at byte 55, length 0x1B8.
  - 64 bytes → 2 blocks; second block starts with 0x80, length 0x200.
- Backpressure: hold `din_v=1` through ISSUE/WAIT → `din_rdy=0`, no byte lost or duplicated, digest matches the reference model. Back-to-back messages → `H` reloads IV; second digest is independent of the first.
- Drop `rst_n` during WAIT of the 2nd block of 64-byte message, then send "abc" → stale `res_v` ignored, "abc" digest correct, only 1 `blk_v` after reset.
